// File: rtl/regfile_sb.sv
// Parametrised 2R/2W register file with same-cycle write forwarding and a
// per-register busy scoreboard for read-after-write hazard detection.
module regfile_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we0,
  input  logic [ADDR_W-1:0]         waddr0,
  input  logic [DATA_W-1:0]         wdata0,
  input  logic                      we1,
  input  logic [ADDR_W-1:0]         waddr1,
  input  logic [DATA_W-1:0]         wdata1,
  input  logic [ADDR_W-1:0]         raddr0,
  input  logic [ADDR_W-1:0]         raddr1,
  output logic [DATA_W-1:0]         rdata0,
  output logic [DATA_W-1:0]         rdata1,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      rbusy0,
  output logic                      rbusy1,
  output logic [(1<<ADDR_W)-1:0]    busy_vec
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [ADDR_W-1:0] ra    [2];
  logic [DATA_W-1:0] rd_c  [2];
  logic              rb_c  [2];

  assign ra[0] = raddr0;
  assign ra[1] = raddr1;

  // Next storage and scoreboard state; port 1 wins a write collision,
  // and a same-cycle issue supersedes the retiring writer's clear.
  always_comb begin
    logic hit0;
    logic hit1;
    for (int r = 0; r < int'(DEPTH); r++) begin
      regs_d[r] = regs_q[r];
      busy_d[r] = busy_q[r];
    end
    for (int r = 0; r < int'(DEPTH); r++) begin
      hit0 = we0 && (waddr0 == ADDR_W'(r));
      hit1 = we1 && (waddr1 == ADDR_W'(r));
      if (hit0) regs_d[r] = wdata0;
      if (hit1) regs_d[r] = wdata1;
      if (hit0 || hit1) busy_d[r] = 1'b0;
      if (issue_en && (issue_addr == ADDR_W'(r))) busy_d[r] = 1'b1;
      if (ZERO_R0 && (r == 0)) begin
        regs_d[r] = '0;
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(DEPTH); r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 0; r < int'(DEPTH); r++) regs_q[r] <= regs_d[r];
      busy_q <= busy_d;
    end
  end

  // Read ports: hardwired zero, then port 1 bypass, port 0 bypass, storage.
  always_comb begin
    logic fw0;
    logic fw1;
    for (int p = 0; p < 2; p++) begin
      fw0     = we0 && (waddr0 == ra[p]);
      fw1     = we1 && (waddr1 == ra[p]);
      rd_c[p] = regs_q[ra[p]];
      if (fw0) rd_c[p] = wdata0;
      if (fw1) rd_c[p] = wdata1;
      rb_c[p] = busy_q[ra[p]] && !(fw0 || fw1);
      if (ZERO_R0 && (ra[p] == '0)) begin
        rd_c[p] = '0;
        rb_c[p] = 1'b0;
      end
    end
  end

  assign rdata0   = rd_c[0];
  assign rdata1   = rd_c[1];
  assign rbusy0   = rb_c[0];
  assign rbusy1   = rb_c[1];
  assign busy_vec = busy_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the pipelined processor core, replacing the fixed 8×16 single-write register file. It provides two asynchronous read ports and two synchronous write ports; the second write port serves dual-destination instructions (e.g. SWAP). Read ports forward same-cycle write data, which removes the need for a zero-delay write workaround. A per-register busy scoreboard lets decode detect read-after-write hazards against in-flight writers.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 0, if 1 then register 0 always reads 0, ignores writes and is never busy
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr0, raddr1  in  ADDR_W  read addresses
- rdata0, rdata1  out  DATA_W  read data (combinational)
- issue_en  in  1  mark issue_addr busy (an instruction writing it has issued)
- issue_addr  in  ADDR_W  destination being issued
- rbusy0, rbusy1  out  1  busy state of raddr0/raddr1 after same-cycle writeback clear
- busy_vec  out  DEPTH  registered busy bit per register

## Operation
- Storage: DEPTH × DATA_W flops. No $display or simulation-only side effects in RTL.
- Write: on posedge clk, if weN then reg[waddrN] <= wdataN.
  - Both ports write to the same address: port 1 wins.
  - If ZERO_R0 = 1, writes to address 0 are dropped.
- Read, per port, is combinational with this priority:
  1. ZERO_R0 = 1 and the address is 0 -> output 0.
  2. we1 = 1 and waddr1 equals the read address -> output wdata1.
  3. we0 = 1 and waddr0 equals the read address -> output wdata0.
  4. Otherwise -> output the stored value.
- Scoreboard, per register r, updated on posedge:
  - Clear when (we0 and waddr0 == r) or (we1 and waddr1 == r).
  - Set when issue_en = 1 and issue_addr == r.
  - Set and clear in the same cycle: set wins, because a new producer supersedes the one retiring.
  - Setting an already-busy register leaves it busy. The scoreboard is single-outstanding per register and does not count writers.
- rbusyN is combinational. It equals busy_vec[raddrN] AND NOT (a same-cycle write to raddrN). The same-cycle issue of raddrN does not affect rbusyN.
- ZERO_R0 = 1: busy_vec[0] is held at 0 and rbusy for address 0 is 0.
- A write to a non-busy register is legal. It updates the data and leaves the busy bit at 0.

## Timing
- Reset: asserting rst immediately (asynchronously) clears all registers to 0 and busy_vec to 0.
  - Because reads are combinational, rdata0/rdata1 show 0 and rbusy0/rbusy1 show 0 while rst is high, except for forwarded same-cycle write data.
  - Writes and issues are ignored while rst is high.
  - Deasserting rst mid-operation loses all in-flight busy state. The pipeline must be flushed by the same reset.
- Write latency: 0 cycles to the read ports through the bypass, 1 edge to storage and to the busy clear.
- Issue latency: busy_vec bit rises 1 edge after issue_en is sampled.
- Read latency: combinational path from raddr/waddr/we/wdata to rdata. There is no registered output.
- No handshake: the block never stalls. Decode uses rbusyN to stall.

## Test plan
- Reset: write 0xBEEF to r3 and assert rst for 1 cycle asynchronously, mid-cycle. Required: rdata for r3 = 0 immediately, busy_vec = 0; a write during rst is not committed.
- Bypass: we0=1, waddr0=5, wdata0=0x1234, raddr0=5 in the same cycle. Required: rdata0 = 0x1234 that cycle; after the edge with we0=0, rdata0 = 0x1234 from storage.
- Dual-write collision: we0/we1 both target r2 with 0x0AAA and 0x0BBB. Required: rdata (r2) = 0x0BBB both in the same cycle and after the edge.
- SWAP: r1=0x0011 and r2=0x0022. Then we0 r1 <- 0x0022 and we1 r2 <- 0x0011 in one cycle. Required: after the edge, r1 = 0x0022 and r2 = 0x0011.
- Scoreboard:
  - Issue r4 at cycle 0. Required: busy_vec[4] = 1 at cycle 1.
  - At cycle 3, with we1 to r4 and raddr1 = 4. Required: rbusy1 = 0 in cycle 3 and busy_vec[4] = 0 after the edge.
  - Issue r4 and write r4 in the same cycle. Required: busy_vec[4] = 1 after the edge.
- ZERO_R0=1: write 0xFFFF to r0 and issue r0. Required: rdata = 0, rbusy = 0 and busy_vec[0] = 0 throughout.
- ZERO_R0=0, DATA_W=32, ADDR_W=5: write 0xDEADBEEF to r31. Required: r31 reads back 0xDEADBEEF.
